// File: rtl/me_search_if.sv
// Motion-estimator search bus: start/busy/completed handshake,
// R/S memory address+data, and result fields.
interface me_search_if #(
  parameter int BLK  = 16,
  parameter int SRCH = 16,
  parameter int SW   = 32
);
  localparam int LB = $clog2(BLK);
  localparam int LS = $clog2(SRCH);
  localparam int LW = $clog2(SW);

  logic            start;
  logic            busy;
  logic            completed;
  logic [2*LB-1:0] AddressR;
  logic [2*LW-1:0] AddressS1;
  logic [7:0]      R;
  logic [7:0]      S1;
  logic [7:0]      BestDist;
  logic [LS-1:0]   motionX;
  logic [LS-1:0]   motionY;

  modport master (
    input  start, R, S1,
    output busy, completed,
    output AddressR, AddressS1,
    output BestDist, motionX, motionY
  );

  modport slave (
    output start, R, S1,
    input  busy, completed,
    input  AddressR, AddressS1,
    input  BestDist, motionX, motionY
  );
endinterface

// File: rtl/me_search_ctrl.sv
// Full-search block-matching sequencer: walks cy,cx,py,px, accumulates
// SAD=sum|R-S1| per candidate, keeps the strict minimum.
// Ports: clk, reset (sync, active-high), bus (me_search_if.master):
//   start/busy/completed, AddressR/AddressS1 out, R/S1 in (1-cycle
//   latency), BestDist (saturated)/motionX/motionY results.
module me_search_ctrl #(
  parameter int BLK  = 16,
  parameter int SRCH = 16,
  parameter int SW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  me_search_if.master   bus
);
  localparam int LB = $clog2(BLK);
  localparam int LS = $clog2(SRCH);
  localparam int LW = $clog2(SW);
  localparam int CW = 2*LB + 2*LS;
  localparam int AW = 2*LB + 8;

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t r_state, w_state_nxt;
  logic   w_accept, w_issue, w_done;

  // Counter fields, LSB first: px, py, cx, cy.
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [2*LW-1:0] r_addr_s;
  logic [LB-1:0]   w_px, w_py;
  logic [LS-1:0]   w_cx, w_cy;
  logic [LW-1:0]   w_sx, w_sy;

  logic            r_vld, r_last;
  logic [LS-1:0]   r_dx, r_dy;
  logic [7:0]      w_diff;
  logic [AW-1:0]   r_acc, r_best, w_sad;
  logic [LS-1:0]   r_bx, r_by;

  logic            r_busy, r_comp;
  logic [7:0]      r_bd;
  logic [LS-1:0]   r_mx, r_my;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_issue = 1'b1;
        if (&r_cnt) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next S address is formed from the incremented counter so the
  // registered address lines up with r_cnt; wrap returns it to 0.
  assign w_cnt_nxt = r_cnt + CW'(1);
  assign w_px = w_cnt_nxt[LB-1:0];
  assign w_py = w_cnt_nxt[2*LB-1:LB];
  assign w_cx = w_cnt_nxt[2*LB+LS-1:2*LB];
  assign w_cy = w_cnt_nxt[CW-1:2*LB+LS];
  assign w_sx = LW'(w_cx) + LW'(w_px);
  assign w_sy = LW'(w_cy) + LW'(w_py);

  always_ff @(posedge clk) begin
    if (reset || w_accept) begin
      r_cnt    <= '0;
      r_addr_s <= '0;
    end else if (w_issue) begin
      r_cnt    <= w_cnt_nxt;
      r_addr_s <= {w_sy, w_sx};
    end
  end

  // Tag travelling with the data beat that returns next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld  <= 1'b0;
      r_last <= 1'b0;
      r_dx   <= '0;
      r_dy   <= '0;
    end else begin
      r_vld  <= w_issue;
      r_last <= &r_cnt[2*LB-1:0];
      r_dx   <= r_cnt[2*LB+LS-1:2*LB];
      r_dy   <= r_cnt[CW-1:2*LB+LS];
    end
  end

  assign w_diff = (bus.R > bus.S1) ? bus.R - bus.S1
                                   : bus.S1 - bus.R;
  assign w_sad  = r_acc + AW'(w_diff);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc  <= '0;
      r_best <= '0;
      r_bx   <= '0;
      r_by   <= '0;
    end else if (w_accept) begin
      r_acc  <= '0;
      r_best <= '1;
    end else if (r_vld) begin
      if (r_last) begin
        r_acc <= '0;
        if (w_sad < r_best) begin
          r_best <= w_sad;
          r_bx   <= r_dx;
          r_by   <= r_dy;
        end
      end else begin
        r_acc <= w_sad;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_comp <= 1'b0;
      r_bd   <= '0;
      r_mx   <= '0;
      r_my   <= '0;
    end else begin
      r_comp <= w_done;
      if (w_accept)    r_busy <= 1'b1;
      else if (w_done) r_busy <= 1'b0;
      if (w_done) begin
        r_bd <= (|r_best[AW-1:8]) ? 8'hFF : r_best[7:0];
        r_mx <= r_bx;
        r_my <= r_by;
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.completed = r_comp;
  assign bus.AddressR  = r_cnt[2*LB-1:0];
  assign bus.AddressS1 = r_addr_s;
  assign bus.BestDist  = r_bd;
  assign bus.motionX   = r_mx;
  assign bus.motionY   = r_my;
endmodule

// File: tb/tb_me_search_ctrl.sv
// Bench for me_search_ctrl: two instances (4/4/8 and 2/2/4), random
// memories, behavioural SAD model and per-cycle output compare.
module tb_me_search_ctrl;
  localparam int BA = 4, SA = 4, WA = 8;
  localparam int BB = 2, SB = 2, WB = 4;
  localparam int NA = BA*BA*SA*SA;
  localparam int NB = BB*BB*SB*SB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst[2];
  logic st[2];
  bit [7:0] rm[2][256];
  bit [7:0] sm[2][256];
  int pb[2] = '{BA, BB};
  int ps[2] = '{SA, SB};
  int pw[2] = '{WA, WB};
  int pn[2] = '{NA, NB};

  int n_chk = 0;
  int n_err = 0;

  me_search_if #(.BLK(BA), .SRCH(SA), .SW(WA)) ifa();
  me_search_if #(.BLK(BB), .SRCH(SB), .SW(WB)) ifb();

  me_search_ctrl #(.BLK(BA), .SRCH(SA), .SW(WA)) ua (
    .clk(clk), .reset(rst[0]), .bus(ifa.master));
  me_search_ctrl #(.BLK(BB), .SRCH(SB), .SW(WB)) ub (
    .clk(clk), .reset(rst[1]), .bus(ifb.master));

  assign ifa.start = st[0];
  assign ifb.start = st[1];

  always @(posedge clk) begin
    ifa.R  <= rm[0][ifa.AddressR];
    ifa.S1 <= sm[0][ifa.AddressS1];
    ifb.R  <= rm[1][ifb.AddressR];
    ifb.S1 <= sm[1][ifb.AddressS1];
  end

  int o_ar[2], o_as[2], o_bd[2], o_mx[2], o_my[2];
  logic o_bs[2], o_cp[2];
  always_comb begin
    o_ar[0] = int'(ifa.AddressR);  o_ar[1] = int'(ifb.AddressR);
    o_as[0] = int'(ifa.AddressS1); o_as[1] = int'(ifb.AddressS1);
    o_bd[0] = int'(ifa.BestDist);  o_bd[1] = int'(ifb.BestDist);
    o_mx[0] = int'(ifa.motionX);   o_mx[1] = int'(ifb.motionX);
    o_my[0] = int'(ifa.motionY);   o_my[1] = int'(ifb.motionY);
    o_bs[0] = ifa.busy;            o_bs[1] = ifb.busy;
    o_cp[0] = ifa.completed;       o_cp[1] = ifb.completed;
  end

  // ---------------- reference model ----------------
  int m_t[2] = '{-1, -1};
  int m_res[2][3];
  int m_nxt[2][3];
  bit m_cp[2];

  function automatic int sad_of(int k, int cx, int cy);
    int s = 0;
    int b = pb[k];
    int w = pw[k];
    for (int py = 0; py < b; py++)
      for (int px = 0; px < b; px++) begin
        int d = int'(rm[k][py*b+px])
              - int'(sm[k][(cy+py)*w+cx+px]);
        s += (d < 0) ? -d : d;
      end
    return s;
  endfunction

  function automatic void predict(int k);
    int best = 1 << 30;
    int bx = 0, by = 0;
    for (int cy = 0; cy < ps[k]; cy++)
      for (int cx = 0; cx < ps[k]; cx++) begin
        int s = sad_of(k, cx, cy);
        if (s < best) begin
          best = s; bx = cx; by = cy;
        end
      end
    m_nxt[k][0] = (best > 255) ? 255 : best;
    m_nxt[k][1] = bx;
    m_nxt[k][2] = by;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 3; j++) begin
        m_res[k][j] = 0;
        m_nxt[k][j] = 0;
      end
  end

  // m_t = cycles since the accepting edge, -1 when idle.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_cp[k] = 1'b0;
      if (rst[k]) begin
        m_t[k] = -1;
        for (int j = 0; j < 3; j++) m_res[k][j] = 0;
      end else if (m_t[k] < 0) begin
        if (st[k]) begin
          m_t[k] = 0;
          predict(k);
        end
      end else begin
        m_t[k]++;
        if (m_t[k] == pn[k] + 2) begin
          m_t[k] = -1;
          m_cp[k] = 1'b1;
          for (int j = 0; j < 3; j++) m_res[k][j] = m_nxt[k][j];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int t, b, s, px, py, cx, cy, ear, eas, eb;
      t = m_t[k]; b = pb[k]; s = ps[k];
      ear = 0; eas = 0;
      eb = (t >= 0) ? 1 : 0;
      if (t >= 0 && t < pn[k]) begin
        px = t % b;
        py = (t / b) % b;
        cx = (t / (b*b)) % s;
        cy = t / (b*b*s);
        ear = py*b + px;
        eas = (cy+py)*pw[k] + cx + px;
      end
      n_chk++;
      if (int'(o_bs[k]) != eb || int'(o_cp[k]) != int'(m_cp[k]) ||
          o_ar[k] != ear || o_as[k] != eas ||
          o_bd[k] != m_res[k][0] || o_mx[k] != m_res[k][1] ||
          o_my[k] != m_res[k][2]) begin
        n_err++;
        $display("FAIL cycle_cmp inst=%0d t=%0d got b%0d c%0d ar%0d as%0d r(%0d,%0d,%0d) want b%0d c%0d ar%0d as%0d r(%0d,%0d,%0d)",
          k, t, o_bs[k], o_cp[k], o_ar[k], o_as[k],
          o_bd[k], o_mx[k], o_my[k], eb, m_cp[k], ear, eas,
          m_res[k][0], m_res[k][1], m_res[k][2]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic fill(input int k, input int rlo, input int rhi,
                      input int slo, input int shi);
    for (int i = 0; i < 256; i++) begin
      rm[k][i] = 8'($urandom_range(rhi, rlo));
      sm[k][i] = 8'($urandom_range(shi, slo));
    end
  endtask

  task automatic plant(input int k, input int cx, input int cy);
    int b = pb[k];
    int w = pw[k];
    fill(k, 0, 255, 100, 200);
    for (int py = 0; py < b; py++)
      for (int px = 0; px < b; px++)
        rm[k][py*b+px] = sm[k][(cy+py)*w+cx+px];
  endtask

  task automatic run(input int k, input int repulse, input int rstat,
                     output int lat, output bit dn);
    @(negedge clk) st[k] = 1'b1;
    @(posedge clk);
    #1 st[k] = 1'b0;
    lat = 0;
    dn = 1'b0;
    while (lat < pn[k] + 50 && !dn) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rstat >= 0 && lat == rstat + 1) begin
        chk("abort_busy", int'(o_bs[k]), 0);
        chk("abort_ar", o_ar[k], 0);
        chk("abort_as", o_as[k], 0);
        chk("abort_bd", o_bd[k], 0);
      end
      st[k]  = (lat == repulse);
      rst[k] = (lat == rstat);
      if (o_cp[k]) dn = 1'b1;
    end
    st[k]  = 1'b0;
    rst[k] = 1'b0;
  endtask

  task automatic expect_res(input string nm, input int k,
                            input int bd, input int mx, input int my);
    chk({nm, "_bd"}, o_bd[k], bd);
    chk({nm, "_mx"}, o_mx[k], mx);
    chk({nm, "_my"}, o_my[k], my);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit dn;
    rst[0] = 1'b1; rst[1] = 1'b1;
    st[0]  = 1'b1; st[1]  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", int'(o_bs[k]), 0);
      chk("rst_comp", int'(o_cp[k]), 0);
      chk("rst_ar", o_ar[k], 0);
      chk("rst_as", o_as[k], 0);
      expect_res("rst", k, 0, 0, 0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    st[0]  = 1'b0; st[1]  = 1'b0;
    repeat (2) @(negedge clk);

    plant(0, 2, 3);
    run(0, -1, -1, lat, dn);
    chk("plant_lat_a", lat, 258);
    expect_res("plant_a", 0, 0, 2, 3);

    plant(1, 1, 1);
    run(1, -1, -1, lat, dn);
    chk("plant_lat_b", lat, 18);
    expect_res("plant_b", 1, 0, 1, 1);

    fill(0, 0, 0, 0, 0);
    run(0, -1, -1, lat, dn);
    chk("zero_lat", lat, 258);
    expect_res("zero", 0, 0, 0, 0);

    fill(0, 255, 255, 0, 0);
    run(0, -1, -1, lat, dn);
    expect_res("sat_a", 0, 255, 0, 0);
    fill(1, 255, 255, 0, 0);
    run(1, -1, -1, lat, dn);
    expect_res("sat_b", 1, 255, 0, 0);

    fill(0, 0, 255, 0, 255);
    run(0, 100, -1, lat, dn);
    chk("restart_lat", lat, 258);
    fill(0, 0, 255, 0, 255);
    run(0, -1, -1, lat, dn);
    chk("second_lat", lat, 258);

    plant(0, 2, 3);
    run(0, -1, 100, lat, dn);
    chk("abort_nocomp", int'(dn), 0);
    run(0, -1, -1, lat, dn);
    chk("after_abort_lat", lat, 258);
    expect_res("after_abort", 0, 0, 2, 3);

    for (int i = 0; i < 4; i++) begin
      fill(1, 0, 255, 0, 255);
      run(1, -1, -1, lat, dn);
      chk("rand_lat_b", lat, 18);
    end
    fill(1, 0, 255, 0, 255);
    run(1, 5, -1, lat, dn);
    chk("restart_lat_b", lat, 18);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
